// File: rtl/jk_ctrl_pkg.sv
// Shared types for the JK bank command arbiter: command opcodes, FSM states
// and the single-bit JK next-state rule.
package jk_ctrl_pkg;

  localparam int unsigned DEFAULT_RPT_W = 4;

  typedef enum logic [1:0] {
    OP_HOLD   = 2'b00,
    OP_RESET  = 2'b01,
    OP_SET    = 2'b10,
    OP_TOGGLE = 2'b11
  } jk_op_t;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_APPLY = 1'b1
  } state_t;

  function automatic logic jk_next(input logic j, input logic k, input logic q);
    logic nq;
    case ({j, k})
      2'b00:   nq = q;
      2'b01:   nq = 1'b0;
      2'b10:   nq = 1'b1;
      default: nq = ~q;
    endcase
    return nq;
  endfunction

endpackage

// File: rtl/jk_bank.sv
// WIDTH parallel JK flip-flops, asynchronously cleared to zero.
module jk_bank
  import jk_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  always_comb begin
    q_d = q_q;
    for (int unsigned b = 0; b < WIDTH; b++) begin
      q_d[b] = jk_next(j[b], k[b], q_q[b]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/jk_bank_arbiter.sv
// Round-robin arbiter/sequencer: grants one requester at a time and drives the
// JK bank with its op/mask for rpt+1 consecutive edges.
module jk_bank_arbiter
  import jk_ctrl_pkg::*;
#(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned RPT_W = DEFAULT_RPT_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [2*NREQ-1:0]       req_op,
  input  logic [WIDTH*NREQ-1:0]   req_mask,
  input  logic [RPT_W*NREQ-1:0]   req_rpt,
  output logic [WIDTH-1:0]        q,
  output logic                    busy,
  output logic [$clog2(NREQ)-1:0] grant_id,
  output logic                    done
);

  localparam int unsigned IDW = $clog2(NREQ);

  jk_op_t           op_arr   [NREQ];
  logic [WIDTH-1:0] mask_arr [NREQ];
  logic [RPT_W-1:0] rpt_arr  [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign op_arr[gi]   = jk_op_t'(req_op[2*gi +: 2]);
    assign mask_arr[gi] = req_mask[WIDTH*gi +: WIDTH];
    assign rpt_arr[gi]  = req_rpt[RPT_W*gi +: RPT_W];
  end

  state_t           state_q, state_d;
  jk_op_t           cur_op_q, cur_op_d;
  logic [WIDTH-1:0] cur_mask_q, cur_mask_d;
  logic [RPT_W-1:0] cnt_q, cnt_d;
  logic [IDW-1:0]   grant_q, grant_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic             done_q, done_d;

  logic             win_valid;
  logic [IDW-1:0]   win_idx;
  logic [IDW-1:0]   cand;

  logic [WIDTH-1:0] bank_j;
  logic [WIDTH-1:0] bank_k;

  // Search starts one past the last winner so the previous grantee ranks last.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      cand = IDW'((32'(ptr_q) + i) % NREQ);
      if (!win_valid && req_valid[cand]) begin
        win_valid = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    cur_op_d   = cur_op_q;
    cur_mask_d = cur_mask_q;
    cnt_d      = cnt_q;
    grant_d    = grant_q;
    ptr_d      = ptr_q;
    done_d     = 1'b0;
    req_ready  = '0;
    bank_j     = '0;
    bank_k     = '0;

    case (state_q)
      S_IDLE: begin
        if (win_valid) begin
          req_ready  = NREQ'(1) << win_idx;
          cur_op_d   = op_arr[win_idx];
          cur_mask_d = mask_arr[win_idx];
          cnt_d      = rpt_arr[win_idx];
          grant_d    = win_idx;
          state_d    = S_APPLY;
        end
      end

      S_APPLY: begin
        bank_j = cur_mask_q & {WIDTH{cur_op_q[1]}};
        bank_k = cur_mask_q & {WIDTH{cur_op_q[0]}};
        if (cnt_q == '0) begin
          done_d  = 1'b1;
          ptr_d   = grant_q;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cur_op_q   <= OP_HOLD;
      cur_mask_q <= '0;
      cnt_q      <= '0;
      grant_q    <= '0;
      ptr_q      <= IDW'(NREQ - 1);
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_op_q   <= cur_op_d;
      cur_mask_q <= cur_mask_d;
      cnt_q      <= cnt_d;
      grant_q    <= grant_d;
      ptr_q      <= ptr_d;
      done_q     <= done_d;
    end
  end

  jk_bank #(
    .WIDTH(WIDTH)
  ) u_bank (
    .clk  (clk),
    .rst_n(rst_n),
    .j    (bank_j),
    .k    (bank_k),
    .q    (q)
  );

  assign busy     = (state_q == S_APPLY);
  assign grant_id = grant_q;
  assign done     = done_q;

endmodule
